// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg
//   Shared definitions for the peripheral bus master: the controller state
//   encoding and the default bus geometry (address width, data width and
//   per-beat address stride).
package periph_bus_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/periph_bus_master.sv
// periph_bus_master
//   Turns single or burst read/write requests into cycles on a simple
//   registered peripheral bus (cs / we / buffer_address / buffer_data, with
//   read data returned on data_in one cycle after the select cycle).
//
//   Build option: define PERIPH_BUS_MASTER_BURST_EN to honour req_len
//   (req_len+1 beats, address stepping by ADDR_STRIDE). Without it every
//   request is a single beat and req_len is ignored.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     req_valid/ready   request handshake (ready only while idle)
//     req_we            1 = write, 0 = read
//     req_addr          start address
//     req_wdata         write data, repeated on every beat
//     req_len           beats minus one (burst build only)
//     rsp_valid         one-cycle pulse per completed beat
//     rsp_rdata         captured read data, 0 for write beats
//     busy              controller not idle
//     cs, we            peripheral select / write enable
//     buffer_address    peripheral register address (held while deselected)
//     buffer_data       peripheral write data (0 unless writing)
//     data_in           OR of peripheral read data
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] buffer_address,
  output logic [DATA_W-1:0] buffer_data,
  input  logic [DATA_W-1:0] data_in
);

  state_t              state_r, state_s;
  logic                accept_s;
  logic                last_beat_s;
  logic                beat_we_s;
  logic [DATA_W-1:0]   beat_wdata_s;
  logic [ADDR_W-1:0]   beat_addr_s;

  logic                req_ready_r, req_ready_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                busy_r, busy_s;
  logic                cs_r, cs_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   buffer_address_r, buffer_address_s;
  logic [DATA_W-1:0]   buffer_data_r, buffer_data_s;

  // req_ready_r is only high in IDLE, so this is the handshake edge.
  assign accept_s = req_valid & req_ready_r;

`ifdef PERIPH_BUS_MASTER_BURST_EN
  logic [3:0]        beats_left_r;
  logic              op_we_r;
  logic [DATA_W-1:0] wdata_r;

  // Burst bookkeeping: latch the request at accept, count down per completed beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_left_r <= 4'd0;
      op_we_r      <= 1'b0;
      wdata_r      <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      beats_left_r <= req_len;
      op_we_r      <= req_we;
      wdata_r      <= req_wdata;
    end else if (state_r == RESP && !last_beat_s) begin
      beats_left_r <= beats_left_r - 4'd1;
    end
  end

  assign last_beat_s = (beats_left_r == 4'd0);

  // First beat comes straight from the request; later beats replay the latched
  // request one stride past the address just used (wraps modulo 2^ADDR_W).
  always_comb begin
    if (state_r == IDLE) begin
      beat_we_s    = req_we;
      beat_wdata_s = req_wdata;
      beat_addr_s  = req_addr;
    end else begin
      beat_we_s    = op_we_r;
      beat_wdata_s = wdata_r;
      beat_addr_s  = buffer_address_r + ADDR_W'(ADDR_STRIDE);
    end
  end
`else
  // req_len has no meaning in the single-beat build.
  logic unused_len_s;
  assign unused_len_s = ^req_len;
  assign last_beat_s  = 1'b1;
  assign beat_we_s    = req_we;
  assign beat_wdata_s = req_wdata;
  assign beat_addr_s  = req_addr;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    begin
        if (accept_s) begin
          state_s = beat_we_s ? WR : RD_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      WR:      state_s = RESP;
      RD_ADDR: state_s = RD_CAP;
      RD_CAP:  state_s = RESP;
      RESP:    begin
        if (last_beat_s) begin
          state_s = IDLE;
        end else begin
          state_s = beat_we_s ? WR : RD_ADDR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    cs_s          = (state_s == WR) || (state_s == RD_ADDR);
    we_s          = (state_s == WR);
    rsp_valid_s   = (state_s == RESP);
    busy_s        = (state_s != IDLE);
    req_ready_s   = (state_s == IDLE);
    buffer_data_s = (state_s == WR) ? beat_wdata_s : {DATA_W{1'b0}};
    if (cs_s) begin
      buffer_address_s = beat_addr_s;
    end else begin
      buffer_address_s = buffer_address_r;
    end
    // Peripheral data is valid during RD_CAP, i.e. captured on the edge into RESP.
    if (state_r == RD_CAP) begin
      rsp_rdata_s = data_in;
    end else if (state_r == WR) begin
      rsp_rdata_s = {DATA_W{1'b0}};
    end else begin
      rsp_rdata_s = rsp_rdata_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r      <= 1'b0;
      rsp_valid_r      <= 1'b0;
      rsp_rdata_r      <= {DATA_W{1'b0}};
      busy_r           <= 1'b0;
      cs_r             <= 1'b0;
      we_r             <= 1'b0;
      buffer_address_r <= {ADDR_W{1'b0}};
      buffer_data_r    <= {DATA_W{1'b0}};
    end else begin
      req_ready_r      <= req_ready_s;
      rsp_valid_r      <= rsp_valid_s;
      rsp_rdata_r      <= rsp_rdata_s;
      busy_r           <= busy_s;
      cs_r             <= cs_s;
      we_r             <= we_s;
      buffer_address_r <= buffer_address_s;
      buffer_data_r    <= buffer_data_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign busy           = busy_r;
  assign cs             = cs_r;
  assign we             = we_r;
  assign buffer_address = buffer_address_r;
  assign buffer_data    = buffer_data_r;

endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master
//   Self-checking bench for periph_bus_master. A registered responder model
//   returns addr ^ 0x34 one cycle after a read select. Expected bus beats and
//   responses are queued when a request is issued and popped by a monitor as
//   the DUT produces them; scenario tasks check latency and handshake timing.
module tb_periph_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [3:0] req_len = 4'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       cs;
  logic       we;
  logic [7:0] buffer_address;
  logic [7:0] buffer_data;
  logic [7:0] data_in;

`ifdef PERIPH_BUS_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  periph_bus_master #(.ADDR_W(8), .DATA_W(8), .ADDR_STRIDE(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .cs(cs), .we(we), .buffer_address(buffer_address),
    .buffer_data(buffer_data), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cs_count = 0;
  int rsp_count = 0;
  int rsp_edge = 0;
  logic [7:0] last_rdata = 8'h00;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;
  bus_t       bus_q[$];
  logic [7:0] rsp_q[$];
  bus_t       exp_bus;
  logic [7:0] exp_rsp;

  function automatic logic [7:0] resp_fn(input logic [7:0] a);
    return a ^ 8'h34;
  endfunction

  // Registered responder: data appears the cycle after the read select.
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) rd_q <= (cs && !we) ? resp_fn(buffer_address) : 8'h00;
  assign data_in = rd_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard bus beats and responses, check idle bus values.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (cs) begin
        cs_count++;
        if (bus_q.size() == 0) begin
          miscompares++;
          $display("FAIL bus_beat: got unexpected beat addr=%h we=%b data=%h, required none", buffer_address, we, buffer_data);
        end else begin
          exp_bus = bus_q.pop_front();
          if ({we, buffer_address, buffer_data} !== {exp_bus.we, exp_bus.addr, exp_bus.data}) begin
            miscompares++;
            $display("FAIL bus_beat: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     we, buffer_address, buffer_data, exp_bus.we, exp_bus.addr, exp_bus.data);
          end
        end
      end else if (we !== 1'b0 || buffer_data !== 8'h00) begin
        miscompares++;
        $display("FAIL bus_idle: got we=%b data=%h, required we=0 data=00", we, buffer_data);
      end
      if (rsp_valid) begin
        rsp_count++;
        rsp_edge   = cyc + 1;
        last_rdata = rsp_rdata;
        vectors++;
        if (rsp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp: got unexpected rsp rdata=%h, required none", rsp_rdata);
        end else begin
          exp_rsp = rsp_q.pop_front();
          if (rsp_rdata !== exp_rsp) begin
            miscompares++;
            $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, exp_rsp);
          end
        end
      end
    end
  end

  // Drive a request (called #1 after a rising edge); queue its expectations.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [3:0] l, input bit push, output int acc_edge, output bit ok);
    int   beats;
    logic rdy;
    logic [7:0] ba;
    beats = BURST ? (int'(l) + 1) : 1;
    if (push) begin
      for (int i = 0; i < beats; i++) begin
        ba = a + 8'(4 * i);
        bus_q.push_back('{we: w, addr: ba, data: (w ? d : 8'h00)});
        rsp_q.push_back(w ? 8'h00 : resp_fn(ba));
      end
    end
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_len = l;
    ok = 1'b0; acc_edge = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; acc_edge = cyc; end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (rsp_count >= target) ok = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, busy, cs, we, buffer_address, buffer_data} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h busy=%b cs=%b we=%b a=%h d=%h, required all 0",
               req_ready, rsp_valid, rsp_rdata, busy, cs, we, buffer_address, buffer_data);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_write;
    int a; bit ok; int r0; int c0;
    r0 = rsp_count; c0 = cs_count;
    issue(1'b1, 8'h04, 8'hA5, 4'd0, 1'b1, a, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL write_accept: got no accept, required accept"); end
    wait_rsp(r0 + 1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL write_rsp: got timeout, required rsp_valid"); end
    vectors++;
    if (rsp_edge - a !== 2) begin
      miscompares++; $display("FAIL write_latency: got %0d, required 2", rsp_edge - a);
    end
    idle_cycles(3);
    vectors++;
    if (cs_count - c0 !== 1 || rsp_count - r0 !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_counts: got cs=%0d rsp=%0d busy=%b, required 1 1 0", cs_count - c0, rsp_count - r0, busy);
    end
  endtask

  task automatic test_read;
    int a; bit ok; int r0; int c0;
    r0 = rsp_count; c0 = cs_count;
    issue(1'b0, 8'h08, 8'h77, 4'd0, 1'b1, a, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL read_accept: got no accept, required accept"); end
    wait_rsp(r0 + 1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL read_rsp: got timeout, required rsp_valid"); end
    vectors++;
    if (rsp_edge - a !== 3) begin
      miscompares++; $display("FAIL read_latency: got %0d, required 3", rsp_edge - a);
    end
    vectors++;
    if (last_rdata !== 8'h3C) begin
      miscompares++; $display("FAIL read_data: got %h, required 3c", last_rdata);
    end
    idle_cycles(3);
    vectors++;
    if (cs_count - c0 !== 1 || rsp_count - r0 !== 1) begin
      miscompares++; $display("FAIL read_counts: got cs=%0d rsp=%0d, required 1 1", cs_count - c0, rsp_count - r0);
    end
  endtask

  task automatic test_burst;
    int a; bit ok; int r0; int c0; int nb;
    r0 = rsp_count; c0 = cs_count;
    nb = BURST ? 3 : 1;
    issue(1'b0, 8'hF8, 8'h00, 4'd2, 1'b1, a, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL burst_accept: got no accept, required accept"); end
    wait_rsp(r0 + nb, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL burst_rsp: got timeout, required %0d rsp", nb); end
    idle_cycles(12);
    vectors++;
    if (cs_count - c0 !== nb || rsp_count - r0 !== nb || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_read_counts: got cs=%0d rsp=%0d busy=%b, required %0d %0d 0",
               cs_count - c0, rsp_count - r0, busy, nb, nb);
    end
`ifdef PERIPH_BUS_MASTER_BURST_EN
    r0 = rsp_count; c0 = cs_count;
    issue(1'b1, 8'h10, 8'h5A, 4'd1, 1'b1, a, ok);
    wait_rsp(r0 + 2, ok);
    idle_cycles(6);
    vectors++;
    if (!ok || cs_count - c0 !== 2 || rsp_count - r0 !== 2) begin
      miscompares++;
      $display("FAIL burst_write_counts: got cs=%0d rsp=%0d, required 2 2", cs_count - c0, rsp_count - r0);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int a1; int a2; bit ok1; bit ok2; bit ok; int r0;
    r0 = rsp_count;
    issue(1'b1, 8'h20, 8'h11, 4'd0, 1'b1, a1, ok1);
    vectors++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_busy: got ready=%b busy=%b, required 0 1", req_ready, busy);
    end
    issue(1'b0, 8'h30, 8'h00, 4'd0, 1'b1, a2, ok2);
    vectors++;
    if (!ok1 || !ok2 || a2 - a1 !== 3) begin
      miscompares++;
      $display("FAIL b2b_accept: got second accept %0d edges after first, required 3", a2 - a1);
    end
    wait_rsp(r0 + 2, ok);
    idle_cycles(3);
    vectors++;
    if (!ok || rsp_count - r0 !== 2) begin
      miscompares++; $display("FAIL b2b_rsp: got %0d rsp, required 2", rsp_count - r0);
    end
  endtask

  task automatic test_reset_mid;
    int a; bit ok; int r0;
    r0 = rsp_count;
    issue(1'b0, 8'h40, 8'h00, 4'd0, 1'b0, a, ok);
    vectors++;
    if (!ok || cs !== 1'b1) begin
      miscompares++; $display("FAIL midrst_rdaddr: got cs=%b, required 1", cs);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (cs !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || buffer_address !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_async: got cs=%b busy=%b ready=%b addr=%h, required 0 0 0 00", cs, busy, req_ready, buffer_address);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_ready: got %b, required 1", req_ready);
    end
    idle_cycles(6);
    vectors++;
    if (rsp_count !== r0) begin
      miscompares++; $display("FAIL midrst_rsp: got %0d rsp, required 0", rsp_count - r0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d beats %0d rsp pending, required 0 0", bus_q.size(), rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
